keypad_input_conditioner: RTL and testbench
===========================================

# keypad_input_conditioner

Front-end stage directly upstream of `water_dispenser`, between the board's raw pins and the dispenser's control inputs. Synchronizes the digit switches and the three active-low push-buttons, debounces the buttons, and emits one-cycle command pulses. Each add command carries the lowest-numbered active switch as a decoded digit. The dispenser then only ever sees clean, single-cycle, mutually exclusive commands.

## Interface
- `SWITCH_COUNT`, 10: number of digit switches; switch *i* means digit *i*.
- `DEBOUNCE_CYCLES`, 2: consecutive synchronized samples that must differ from the current debounced level before that level changes; legal range 1–255.
- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `switches`  in  SWITCH_COUNT  raw digit switches, active-high, asynchronous.
- `button_add`  in  1  raw, active-low, asynchronous.
- `button_ok`  in  1  raw, active-low, asynchronous.
- `button_cancel`  in  1  raw, active-low, asynchronous.
- `add_pulse`  out  1  one-cycle add command; `digit` is valid while it is high.
- `ok_pulse`  out  1  one-cycle confirm command.
- `cancel_pulse`  out  1  one-cycle cancel command.
- `digit`  out  $clog2(SWITCH_COUNT)  index of the lowest active switch, captured with the last `add_pulse`.

## Operation
- Every raw input passes through a 2-flop synchronizer. Button synchronizer flops reset to 1 (released); switch synchronizer flops reset to 0.
- Each button has its own debouncer:
  - Debounced level resets to 1.
  - An 8-bit counter increments on every edge where the synchronized value ≠ debounced level.
  - The counter clears on every edge where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A press is a 1→0 transition of the debounced level. A release (0→1) produces nothing. A held button yields exactly one press; the next press requires a debounced release first.
- Arbitration happens when presses occur on the same edge:
  - Priority is cancel > ok > add.
  - Only the winner pulses. The losers are discarded, not queued.
- Add qualification:
  - On an add press, if any synchronized switch is 1, `add_pulse` asserts and `digit` loads the lowest set index.
  - If no switch is set, the press is discarded: no pulse, `digit` unchanged.
- `digit` holds its value between add pulses.
- Reset values: `add_pulse`/`ok_pulse`/`cancel_pulse` = 0, `digit` = 0, all counters = 0.
- Reset asserted mid-debounce clears all state immediately and drops any pending press.
- A button still held low when reset deasserts is treated as a fresh press, following the normal latency.

## Timing
- Latency, with edge 0 defined as the first rising edge that samples the raw pin low:
  - Edge 1: synchronized value low.
  - Edge DEBOUNCE_CYCLES+1: debounced level low.
  - Edge DEBOUNCE_CYCLES+2: pulse registers high.
  - Edge DEBOUNCE_CYCLES+3: pulse low.
- All outputs are registered. At most one of the three pulses is high in any cycle.
- A low glitch is rejected if it is seen on fewer than DEBOUNCE_CYCLES consecutive synchronized samples.
- A release must likewise persist for DEBOUNCE_CYCLES samples before the button can re-arm.
- Switches have no debounce. `digit` reflects the synchronized switches at the edge where the press is detected (edge DEBOUNCE_CYCLES+1).
- Switch changes within the final 2 cycles before that edge may or may not be captured. The bench must keep switches stable ≥3 cycles around add presses.

## Structure
- Package `keypad_pkg`: `SWITCH_COUNT` default, `DIGIT_WIDTH` = $clog2(SWITCH_COUNT), `DEBOUNCE_WIDTH` = 8, and the command enum `CMD_NONE`/`CMD_ADD`/`CMD_OK`/`CMD_CANCEL` used by the arbiter.
- Sub-module `button_debouncer` (synchronizer + counter + press detect, output `press`), instantiated three times.
- The top level holds the switch synchronizer, lowest-set priority encoder, arbiter, and output registers.

## Test plan
- Reset held 7 clocks, then released, all buttons high → every output 0, `digit` = 0, no pulse for 20 clocks.
- `switches[3]` = 1, `button_add` low for 5 clocks, DEBOUNCE_CYCLES = 2 → exactly one `add_pulse` at edge 4 after the first low sample, with `digit` = 3. Hold the button 30 clocks → still one pulse.
- `switches[8]`, `switches[3]`, `switches[6]` all set, then add press → `digit` = 3. Repeat with `switches[9]`, `switches[5]`, `switches[0]` → `digit` = 0.
- Bounce on `button_ok`: low 1 clock, high 1, low 1, then stable low → no pulse from the glitches; one `ok_pulse` DEBOUNCE_CYCLES+2 edges after the stable low begins. Add press with switches all 0 → no pulse, `digit` unchanged.
- `button_cancel` and `button_add` (with a switch set) fall on the same edge → only `cancel_pulse`; the add press is lost, and no `add_pulse` follows while add stays held.
- Reset asserted while `button_ok` has been low for 1 synchronized cycle → no `ok_pulse` during reset. With the button still low after reset deasserts → one `ok_pulse` DEBOUNCE_CYCLES+2 edges after reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and command encoding for the keypad input conditioner.
package keypad_pkg;

  localparam int unsigned SWITCH_COUNT_DEFAULT = 10;
  localparam int unsigned DIGIT_WIDTH          = $clog2(SWITCH_COUNT_DEFAULT);
  localparam int unsigned DEBOUNCE_WIDTH       = 8;

  // Winner of same-edge press arbitration
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_ADD,
    CMD_OK,
    CMD_CANCEL
  } cmd_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw active-low button, debounces it and emits a one-cycle
// registered press strobe on each debounced 1->0 transition.
module button_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CountLast = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]                sync_q;
  logic                      level_q, level_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      press_q, press_d;

  // Counter runs while the synchronized sample disagrees with the debounced level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CountLast) begin
        level_d = ~level_q;
        // Only the falling edge of the debounced level is a press
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and press register; released is the reset state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/keypad_input_conditioner.sv
// Turns raw digit switches and three active-low buttons into clean, mutually
// exclusive one-cycle commands for the dispenser.
module keypad_input_conditioner
  import keypad_pkg::*;
#(
  parameter int unsigned SWITCH_COUNT    = SWITCH_COUNT_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [SWITCH_COUNT-1:0]         switches,
  input  logic                            button_add,
  input  logic                            button_ok,
  input  logic                            button_cancel,
  output logic                            add_pulse,
  output logic                            ok_pulse,
  output logic                            cancel_pulse,
  output logic [$clog2(SWITCH_COUNT)-1:0] digit
);

  localparam int unsigned DIGIT_BITS = $clog2(SWITCH_COUNT);

  logic [SWITCH_COUNT-1:0] sw_meta_q, sw_sync_q;
  logic                    press_add, press_ok, press_cancel;
  logic [DIGIT_BITS-1:0]   lowest;
  cmd_e                    cmd;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
    .clock  (clock),
    .reset  (reset),
    .button (button_add),
    .press  (press_add)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
    .clock  (clock),
    .reset  (reset),
    .button (button_ok),
    .press  (press_ok)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clock  (clock),
    .reset  (reset),
    .button (button_cancel),
    .press  (press_cancel)
  );

  // Two-flop synchronizer for the digit switches (no debounce)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Lowest-set priority encoder: scan downward so the lowest index wins
  always_comb begin
    lowest = '0;
    for (int i = int'(SWITCH_COUNT) - 1; i >= 0; i--) begin
      if (sw_sync_q[i]) lowest = DIGIT_BITS'(i);
    end
  end

  // Arbitration cancel > ok > add; an add with no switch set is dropped
  always_comb begin
    cmd = CMD_NONE;
    if (press_cancel)                  cmd = CMD_CANCEL;
    else if (press_ok)                 cmd = CMD_OK;
    else if (press_add && |sw_sync_q)  cmd = CMD_ADD;
  end

  // Registered command pulses; digit only loads with an issued add
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      add_pulse    <= 1'b0;
      ok_pulse     <= 1'b0;
      cancel_pulse <= 1'b0;
      digit        <= '0;
    end else begin
      add_pulse    <= (cmd == CMD_ADD);
      ok_pulse     <= (cmd == CMD_OK);
      cancel_pulse <= (cmd == CMD_CANCEL);
      if (cmd == CMD_ADD) digit <= lowest;
    end
  end

endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Directed bench for keypad_input_conditioner with DEBOUNCE_CYCLES = 2.
module tb_keypad_input_conditioner;

  localparam int unsigned SW  = 10;
  localparam int unsigned DB  = 2;
  localparam int          LAT = DB + 2;  // edge index of the pulse after first low sample

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] switches = '0;
  logic          button_add = 1'b1;
  logic          button_ok = 1'b1;
  logic          button_cancel = 1'b1;
  logic          add_pulse, ok_pulse, cancel_pulse;
  logic [3:0]    digit;

  int checks = 0;
  int errors = 0;

  int obs_add_n, obs_add_first, obs_ok_n, obs_ok_first;
  int obs_cancel_n, obs_cancel_first, obs_overlap;

  always #5 clock = ~clock;

  keypad_input_conditioner #(
    .SWITCH_COUNT    (SW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .switches      (switches),
    .button_add    (button_add),
    .button_ok     (button_ok),
    .button_cancel (button_cancel),
    .add_pulse     (add_pulse),
    .ok_pulse      (ok_pulse),
    .cancel_pulse  (cancel_pulse),
    .digit         (digit)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Run n cycles, recording pulse counts and the edge index of each first pulse
  task automatic observe(input int n);
    obs_add_n = 0; obs_ok_n = 0; obs_cancel_n = 0; obs_overlap = 0;
    obs_add_first = -1; obs_ok_first = -1; obs_cancel_first = -1;
    for (int k = 0; k < n; k++) begin
      step();
      if (add_pulse) begin
        if (obs_add_n == 0) obs_add_first = k;
        obs_add_n++;
      end
      if (ok_pulse) begin
        if (obs_ok_n == 0) obs_ok_first = k;
        obs_ok_n++;
      end
      if (cancel_pulse) begin
        if (obs_cancel_n == 0) obs_cancel_first = k;
        obs_cancel_n++;
      end
      if (int'(add_pulse) + int'(ok_pulse) + int'(cancel_pulse) > 1) obs_overlap++;
    end
  endtask

  task automatic test_reset();
    repeat (7) step();
    checks++;
    if ({add_pulse, ok_pulse, cancel_pulse} !== 3'b000) begin
      $display("FAIL reset_pulses: got %b want 000", {add_pulse, ok_pulse, cancel_pulse});
      errors++;
    end
    checks++;
    if (digit !== 4'd0) begin
      $display("FAIL reset_digit: got %0d want 0", digit);
      errors++;
    end
    reset = 1'b1;
    observe(20);
    checks++;
    if (obs_add_n + obs_ok_n + obs_cancel_n !== 0) begin
      $display("FAIL idle_pulses: got %0d want 0", obs_add_n + obs_ok_n + obs_cancel_n);
      errors++;
    end
    checks++;
    if (digit !== 4'd0) begin
      $display("FAIL idle_digit: got %0d want 0", digit);
      errors++;
    end
  endtask

  task automatic test_add_single();
    switches = 10'b00_0000_1000;
    repeat (3) step();
    button_add = 1'b0;
    observe(35);
    checks++;
    if (obs_add_n !== 1) begin
      $display("FAIL add_held_count: got %0d want 1", obs_add_n);
      errors++;
    end
    checks++;
    if (obs_add_first !== LAT) begin
      $display("FAIL add_latency: got %0d want %0d", obs_add_first, LAT);
      errors++;
    end
    checks++;
    if (digit !== 4'd3) begin
      $display("FAIL add_digit3: got %0d want 3", digit);
      errors++;
    end
    checks++;
    if (obs_ok_n + obs_cancel_n !== 0) begin
      $display("FAIL add_other_pulses: got %0d want 0", obs_ok_n + obs_cancel_n);
      errors++;
    end
    button_add = 1'b1;
    observe(10);
    checks++;
    if (obs_add_n !== 0) begin
      $display("FAIL add_release: got %0d want 0", obs_add_n);
      errors++;
    end
  endtask

  task automatic test_add_lowest();
    logic [SW-1:0] pats [3];
    logic [3:0]    want [3];
    pats[0] = 10'b01_0100_1000; want[0] = 4'd3;
    pats[1] = 10'b10_0010_0001; want[1] = 4'd0;
    pats[2] = 10'b10_1000_0000; want[2] = 4'd7;
    for (int p = 0; p < 3; p++) begin
      switches = pats[p];
      repeat (3) step();
      button_add = 1'b0;
      observe(12);
      checks++;
      if (obs_add_n !== 1 || obs_add_first !== LAT) begin
        $display("FAIL lowest_pulse[%0d]: got n=%0d at %0d want n=1 at %0d",
                 p, obs_add_n, obs_add_first, LAT);
        errors++;
      end
      checks++;
      if (digit !== want[p]) begin
        $display("FAIL lowest_digit[%0d]: got %0d want %0d", p, digit, want[p]);
        errors++;
      end
      button_add = 1'b1;
      observe(10);
    end
  endtask

  task automatic test_ok_bounce();
    int glitch_pulses;
    glitch_pulses = 0;
    button_ok = 1'b0; observe(1); glitch_pulses += obs_ok_n;
    button_ok = 1'b1; observe(1); glitch_pulses += obs_ok_n;
    button_ok = 1'b0; observe(1); glitch_pulses += obs_ok_n;
    button_ok = 1'b1; observe(1); glitch_pulses += obs_ok_n;
    button_ok = 1'b0;
    observe(20);
    checks++;
    if (glitch_pulses !== 0) begin
      $display("FAIL ok_glitch: got %0d pulses want 0", glitch_pulses);
      errors++;
    end
    checks++;
    if (obs_ok_n !== 1 || obs_ok_first !== LAT) begin
      $display("FAIL ok_stable: got n=%0d at %0d want n=1 at %0d", obs_ok_n, obs_ok_first, LAT);
      errors++;
    end
    button_ok = 1'b1;
    observe(10);
    // Add with no switch set is dropped and leaves digit alone
    switches = '0;
    repeat (3) step();
    button_add = 1'b0;
    observe(12);
    checks++;
    if (obs_add_n !== 0) begin
      $display("FAIL add_noswitch: got %0d pulses want 0", obs_add_n);
      errors++;
    end
    checks++;
    if (digit !== 4'd7) begin
      $display("FAIL add_noswitch_digit: got %0d want 7", digit);
      errors++;
    end
    button_add = 1'b1;
    observe(10);
  endtask

  task automatic test_cancel_vs_add();
    switches = 10'b00_0000_0100;
    repeat (3) step();
    button_cancel = 1'b0;
    button_add    = 1'b0;
    observe(30);
    checks++;
    if (obs_cancel_n !== 1 || obs_cancel_first !== LAT) begin
      $display("FAIL arb_cancel: got n=%0d at %0d want n=1 at %0d",
               obs_cancel_n, obs_cancel_first, LAT);
      errors++;
    end
    checks++;
    if (obs_add_n !== 0) begin
      $display("FAIL arb_add_lost: got %0d pulses want 0", obs_add_n);
      errors++;
    end
    checks++;
    if (digit !== 4'd7) begin
      $display("FAIL arb_digit: got %0d want 7", digit);
      errors++;
    end
    checks++;
    if (obs_overlap !== 0) begin
      $display("FAIL arb_exclusive: got %0d overlapping cycles want 0", obs_overlap);
      errors++;
    end
    button_cancel = 1'b1;
    button_add    = 1'b1;
    observe(10);
  endtask

  task automatic test_reset_mid();
    button_ok = 1'b0;
    step();
    step();
    reset = 1'b0;
    observe(4);
    checks++;
    if (obs_ok_n !== 0) begin
      $display("FAIL midreset_ok: got %0d pulses want 0", obs_ok_n);
      errors++;
    end
    checks++;
    if (digit !== 4'd0) begin
      $display("FAIL midreset_digit: got %0d want 0", digit);
      errors++;
    end
    reset = 1'b1;
    observe(15);
    checks++;
    if (obs_ok_n !== 1 || obs_ok_first !== LAT) begin
      $display("FAIL postreset_ok: got n=%0d at %0d want n=1 at %0d", obs_ok_n, obs_ok_first, LAT);
      errors++;
    end
    button_ok = 1'b1;
    observe(10);
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_add_lowest();
    test_ok_bounce();
    test_cancel_vs_add();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
